// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source for the VGA display path.
//
// Produces the pixel tick, the x/y raster counters with the undelayed active
// flag, and hsync/vsync/blank_n delayed by PIPE_DLY pixel ticks so they line up
// with registered renderer colour. All outputs come straight from flops.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   pix_en        out  pixel tick, one clk wide, once per CLK_DIV clks
//   x, y          out  raster position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   active_pixels out  x < H_ACTIVE && y < V_ACTIVE, aligned with x/y
//   hsync, vsync  out  delayed syncs, asserted level SYNC_POL
//   blank_n       out  delayed active_pixels
//   line_start    out  one-clk pulse on the first clk showing x == 0
//   frame_start   out  one-clk pulse on the first clk showing x == 0 && y == 0
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0,
   parameter int unsigned PIPE_DLY = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active_pixels,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
   localparam logic [9:0] XMax    = 10'(HTotal - 1);
   localparam logic [9:0] YMax    = 10'(VTotal - 1);
   localparam logic [9:0] XActEnd = 10'(H_ACTIVE);
   localparam logic [9:0] YActEnd = 10'(V_ACTIVE);
   localparam logic [9:0] HsFirst = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HsLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VsFirst = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VsLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic       SyncIdle = ~SYNC_POL;

   if (HTotal > 1024 || VTotal > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end
   if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be in 1..8");
   end
   if (PIPE_DLY > 7) begin : g_bad_dly
      $error("vga_timing_gen: PIPE_DLY must be in 0..7");
   end

   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic            pix_en_q, pix_en_d;
   logic [9:0]      x_q, x_d;
   logic [9:0]      y_q, y_d;
   logic            line_start_q, line_start_d;
   logic            frame_start_q, frame_start_d;
   // Stage 0 holds the raw value for the current x/y; stage N is N ticks old.
   logic [PIPE_DLY:0] hs_pipe_q, hs_pipe_d;
   logic [PIPE_DLY:0] vs_pipe_q, vs_pipe_d;
   logic [PIPE_DLY:0] act_pipe_q, act_pipe_d;

   always_comb begin
      div_cnt_d     = (div_cnt_q == DivMax) ? '0 : div_cnt_q + 1'b1;
      pix_en_d      = (div_cnt_q == DivMax);
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      hs_pipe_d     = hs_pipe_q;
      vs_pipe_d     = vs_pipe_q;
      act_pipe_d    = act_pipe_q;

      if (pix_en_q) begin
         if (x_q == XMax) begin
            x_d          = '0;
            line_start_d = 1'b1;
            if (y_q == YMax) begin
               y_d           = '0;
               frame_start_d = 1'b1;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end

         // Raw sync/active are taken from the position being loaded this edge.
         hs_pipe_d[0]  = (x_d >= HsFirst && x_d <= HsLast) ? SYNC_POL : SyncIdle;
         vs_pipe_d[0]  = (y_d >= VsFirst && y_d <= VsLast) ? SYNC_POL : SyncIdle;
         act_pipe_d[0] = (x_d < XActEnd) && (y_d < YActEnd);
         for (int unsigned i = 1; i <= PIPE_DLY; i++) begin
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
            act_pipe_d[i] = act_pipe_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q     <= '0;
         pix_en_q      <= 1'b0;
         x_q           <= XMax;
         y_q           <= YMax;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         hs_pipe_q     <= {(PIPE_DLY + 1){SyncIdle}};
         vs_pipe_q     <= {(PIPE_DLY + 1){SyncIdle}};
         act_pipe_q    <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         pix_en_q      <= pix_en_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         hs_pipe_q     <= hs_pipe_d;
         vs_pipe_q     <= vs_pipe_d;
         act_pipe_q    <= act_pipe_d;
      end
   end

   assign pix_en        = pix_en_q;
   assign x             = x_q;
   assign y             = y_q;
   assign active_pixels = act_pipe_q[0];
   assign hsync         = hs_pipe_q[PIPE_DLY];
   assign vsync         = vs_pipe_q[PIPE_DLY];
   assign blank_n       = act_pipe_q[PIPE_DLY];
   assign line_start    = line_start_q;
   assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Three instances share clk/rst:
//   u0 default 640x480 timing, CLK_DIV=2, PIPE_DLY=2
//   u1 small raster, CLK_DIV=1, PIPE_DLY=0
//   u2 small raster, CLK_DIV=3, PIPE_DLY=3, SYNC_POL=1
// Every output is compared each cycle against a model that derives the whole
// expected state from the number of clk edges since reset release.
module tb_vga_timing_gen;

   typedef struct packed {
      logic       pix_en;
      logic [9:0] x;
      logic [9:0] y;
      logic       act;
      logic       hs;
      logic       vs;
      logic       bn;
      logic       ls;
      logic       fs;
   } obs_t;

   logic clk;
   logic rst;
   int unsigned cyc;
   bit run;
   int n_checks;
   int n_errors;

   obs_t o0, o1, o2;

   vga_timing_gen u0 (
      .clk(clk), .rst(rst), .pix_en(o0.pix_en), .x(o0.x), .y(o0.y),
      .active_pixels(o0.act), .hsync(o0.hs), .vsync(o0.vs), .blank_n(o0.bn),
      .line_start(o0.ls), .frame_start(o0.fs)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .PIPE_DLY(0)
   ) u1 (
      .clk(clk), .rst(rst), .pix_en(o1.pix_en), .x(o1.x), .y(o1.y),
      .active_pixels(o1.act), .hsync(o1.hs), .vsync(o1.vs), .blank_n(o1.bn),
      .line_start(o1.ls), .frame_start(o1.fs)
   );

   vga_timing_gen #(
      .CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .PIPE_DLY(3)
   ) u2 (
      .clk(clk), .rst(rst), .pix_en(o2.pix_en), .x(o2.x), .y(o2.y),
      .active_pixels(o2.act), .hsync(o2.hs), .vsync(o2.vs), .blank_n(o2.bn),
      .line_start(o2.ls), .frame_start(o2.fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clk edges seen since reset was released.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at t=%0t cyc=%0d: got %0d expected %0d", tag, $time, cyc, obs, exp);
      end
   endtask

   // Expected outputs after c clk edges since release. Pixel ticks land on
   // clks D, 2D, ...; each tick's following edge loads the next raster position,
   // starting from pixel 0 = (0,0). Delayed outputs show pixel p-dly.
   function automatic obs_t model(input int c, input int d, input int ha, input int hfp,
                                  input int hsw, input int hbp, input int va, input int vfp,
                                  input int vsw, input int vbp, input bit pol, input int dly);
      obs_t e;
      int ht, vt, n, n_prev, p, q, xq, yq;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      e.pix_en = (c > 0) && (c % d == 0);
      n      = (c == 0) ? 0 : (c - 1) / d;
      n_prev = (c <= 1) ? 0 : (c - 2) / d;
      e.hs = ~pol;
      e.vs = ~pol;
      e.bn = 1'b0;
      e.ls = 1'b0;
      e.fs = 1'b0;
      if (n == 0) begin
         e.x   = 10'(ht - 1);
         e.y   = 10'(vt - 1);
         e.act = 1'b0;
      end else begin
         p     = n - 1;
         e.x   = 10'(p % ht);
         e.y   = 10'((p / ht) % vt);
         e.act = (int'(e.x) < ha) && (int'(e.y) < va);
         e.ls  = (n != n_prev) && (e.x == 10'd0);
         e.fs  = e.ls && (e.y == 10'd0);
         q = p - dly;
         if (q >= 0) begin
            xq   = q % ht;
            yq   = (q / ht) % vt;
            e.hs = (xq >= ha + hfp && xq < ha + hfp + hsw) ? pol : ~pol;
            e.vs = (yq >= va + vfp && yq < va + vfp + vsw) ? pol : ~pol;
            e.bn = (xq < ha) && (yq < va);
         end
      end
      return e;
   endfunction

   task automatic cmp(input string nm, input obs_t o, input obs_t e);
      check({nm, ".pix_en"},      32'(o.pix_en), 32'(e.pix_en));
      check({nm, ".x"},           32'(o.x),      32'(e.x));
      check({nm, ".y"},           32'(o.y),      32'(e.y));
      check({nm, ".active"},      32'(o.act),    32'(e.act));
      check({nm, ".hsync"},       32'(o.hs),     32'(e.hs));
      check({nm, ".vsync"},       32'(o.vs),     32'(e.vs));
      check({nm, ".blank_n"},     32'(o.bn),     32'(e.bn));
      check({nm, ".line_start"},  32'(o.ls),     32'(e.ls));
      check({nm, ".frame_start"}, 32'(o.fs),     32'(e.fs));
   endtask

   task automatic check_all(input int c);
      cmp("u0", o0, model(c, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2));
      cmp("u1", o1, model(c, 1, 16, 2, 3, 2, 6, 1, 2, 1, 1'b0, 0));
      cmp("u2", o2, model(c, 3, 16, 2, 3, 2, 6, 1, 2, 1, 1'b1, 3));
   endtask

   always @(negedge clk) begin
      if (run) check_all(int'(cyc));
   end

   initial begin
      int len;
      n_checks = 0;
      n_errors = 0;
      run = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      run = 1'b1;
      for (int seg = 0; seg < 7; seg++) begin
         @(negedge clk);
         rst = 1'b0;
         // First segment covers two full u0 lines (hsync window and line wrap).
         len = (seg == 0) ? 3600 : int'($urandom_range(3000, 200));
         repeat (len) @(posedge clk);
         // Asynchronous reset part-way through a clk period.
         #($urandom_range(3, 1));
         rst = 1'b1;
         #1;
         check_all(0);
         repeat ($urandom_range(3, 1)) @(posedge clk);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
